// File: rtl/param_delay_line.sv
// param_delay_line: WIDTH-bit, DEPTH-stage shift pipeline with per-stage
// valid, shift enable, synchronous flush and a runtime-selectable tap
// (delay 0..DEPTH). Each stage is its own instance, so no two stages merge.
// Optional macro DLY_TAPS_OUT_EN exposes every stage on taps/taps_vld.

module param_delay_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             d_vld,
  output logic [WIDTH-1:0] q,
  output logic             q_vld
);
  // One stage: reset clears data and valid, flush clears only valid,
  // shift takes the predecessor's pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      q_vld <= 1'b0;
    end else if (clr) begin
      q_vld <= 1'b0;
    end else if (shift) begin
      q     <= d;
      q_vld <= d_vld;
    end
  end
endmodule

module param_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int SELW  = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  input  logic             din_vld,
  input  logic [SELW-1:0]  sel,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  output logic [SELW-1:0]  count,
  output logic             full
`ifdef DLY_TAPS_OUT_EN
  ,output logic [WIDTH*DEPTH-1:0] taps
  ,output logic [DEPTH-1:0]       taps_vld
`endif
);
  localparam logic [SELW-1:0] DEPTH_C = SELW'(DEPTH);

  // Index 0 is the live input (bypass tap); 1..DEPTH are the registers,
  // so tap k reads index k directly.
  logic [DEPTH:0][WIDTH-1:0] data_pipe;
  logic [DEPTH:0]            vld_pipe;
  logic [SELW-1:0]           sel_c;

  assign data_pipe[0] = din;
  assign vld_pipe[0]  = din_vld;

  for (genvar i = 1; i <= DEPTH; i++) begin : g_stage
    param_delay_stage #(.WIDTH(WIDTH)) u_stage (
      .clk   (clk),
      .rst   (rst),
      .shift (en),
      .clr   (flush),
      .d     (data_pipe[i-1]),
      .d_vld (vld_pipe[i-1]),
      .q     (data_pipe[i]),
      .q_vld (vld_pipe[i])
    );
  end

  // Tap mux; out-of-range selects clamp to the deepest stage.
  always_comb begin
    sel_c    = (sel > DEPTH_C) ? DEPTH_C : sel;
    dout     = data_pipe[sel_c];
    dout_vld = vld_pipe[sel_c];
  end

  // Occupancy tracked incrementally from the beat entering and the beat
  // leaving the last stage; both at once leaves it unchanged.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
    end else if (en) begin
      if (vld_pipe[0] && !vld_pipe[DEPTH])
        count <= count + SELW'(1);
      else if (!vld_pipe[0] && vld_pipe[DEPTH])
        count <= count - SELW'(1);
    end
  end

  assign full = (count == DEPTH_C);

`ifdef DLY_TAPS_OUT_EN
  assign taps     = data_pipe[DEPTH:1];
  assign taps_vld = vld_pipe[DEPTH:1];
`endif

endmodule

// File: tb/tb_param_delay_line.sv
// Directed bench for param_delay_line at WIDTH=8, DEPTH=4.
module tb_param_delay_line;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int SELW  = 3;

  logic             clk = 1'b0;
  logic             rst, en, flush, din_vld;
  logic [WIDTH-1:0] din;
  logic [SELW-1:0]  sel;
  logic [WIDTH-1:0] dout;
  logic             dout_vld;
  logic [SELW-1:0]  count;
  logic             full;
`ifdef DLY_TAPS_OUT_EN
  logic [WIDTH*DEPTH-1:0] taps;
  logic [DEPTH-1:0]       taps_vld;
`endif

  int errs = 0;
  int checks = 0;

  param_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .flush    (flush),
    .din      (din),
    .din_vld  (din_vld),
    .sel      (sel),
    .dout     (dout),
    .dout_vld (dout_vld),
    .count    (count),
    .full     (full)
`ifdef DLY_TAPS_OUT_EN
    ,.taps     (taps)
    ,.taps_vld (taps_vld)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tap(input logic [SELW-1:0] s, input logic [7:0] exp_d, input logic exp_v, input string tag);
    sel = s;
    #1;
    chk({tag, "_d"}, 32'(dout), 32'(exp_d));
    chk({tag, "_v"}, 32'(dout_vld), 32'(exp_v));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0; din = '0; din_vld = 1'b0; sel = 3'd1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full",  32'(full),  32'd0);
    tap(3'd1, 8'h00, 1'b0, "rst_tap1");
    tap(3'd4, 8'h00, 1'b0, "rst_tap4");

    // fill with 0x11..0x55, tap at delay 3
    en = 1'b1; din_vld = 1'b1; sel = 3'd3;
    for (int k = 0; k < 5; k++) begin
      din = 8'(8'h11 * (k + 1));
      tick();
      chk($sformatf("fill_count%0d", k), 32'(count), 32'((k < 4) ? k + 1 : 4));
      chk($sformatf("fill_full%0d", k),  32'(full),  32'((k >= 3) ? 1 : 0));
      if (k >= 2) begin
        chk($sformatf("fill_dout%0d", k), 32'(dout), 32'(8'h11 * (k - 1)));
        chk($sformatf("fill_vld%0d", k),  32'(dout_vld), 32'd1);
      end else begin
        chk($sformatf("fill_vld%0d", k),  32'(dout_vld), 32'd0);
      end
    end
    // stages now 0x55,0x44,0x33,0x22

    // zero-latency bypass
    en = 1'b0; din = 8'hA5; din_vld = 1'b1;
    tap(3'd0, 8'hA5, 1'b1, "bypass");
    din_vld = 1'b0;
    tap(3'd0, 8'hA5, 1'b0, "bypass_inv");

    // hold with en=0 while din moves
    din_vld = 1'b1;
    for (int k = 0; k < 3; k++) begin
      din = 8'(8'hE0 + k);
      tick();
      chk($sformatf("hold_count%0d", k), 32'(count), 32'd4);
      tap(3'd4, 8'h22, 1'b1, "hold_tap4");
      tap(3'd1, 8'h55, 1'b1, "hold_tap1");
    end
    en = 1'b1; din = 8'h66; din_vld = 1'b1;
    tick();
    en = 1'b0;
    chk("resume_count", 32'(count), 32'd4);
    tap(3'd4, 8'h33, 1'b1, "resume_tap4");
    tap(3'd2, 8'h55, 1'b1, "resume_tap2");
    tap(3'd1, 8'h66, 1'b1, "resume_tap1");

    // flush with en=1: valids clear, data stays, 0x77 not captured
    en = 1'b1; flush = 1'b1; din = 8'h77;
    tick();
    en = 1'b0; flush = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_full",  32'(full),  32'd0);
    tap(3'd1, 8'h66, 1'b0, "flush_tap1");
    tap(3'd2, 8'h55, 1'b0, "flush_tap2");
    tap(3'd3, 8'h44, 1'b0, "flush_tap3");
    tap(3'd4, 8'h33, 1'b0, "flush_tap4");
    tap(3'd7, 8'h33, 1'b0, "clamp_tap7");
    tap(3'd5, 8'h33, 1'b0, "clamp_tap5");

    // alternating valid at delay 4
    en = 1'b1; sel = 3'd4;
    for (int n = 1; n <= 8; n++) begin
      din = 8'(8'h80 + n - 1);
      din_vld = ((n - 1) % 2 == 0);
      tick();
      chk($sformatf("alt_count%0d", n), 32'(count), 32'((n >= 4) ? 2 : (n + 1) / 2));
      if (n >= 4) begin
        chk($sformatf("alt_vld%0d", n), 32'(dout_vld), 32'(((n - 4) % 2 == 0) ? 1 : 0));
        chk($sformatf("alt_dout%0d", n), 32'(dout), 32'(8'h80 + n - 4));
      end else begin
        chk($sformatf("alt_vld%0d", n), 32'(dout_vld), 32'd0);
      end
    end

    // reset beats flush and en mid-stream
    rst = 1'b1; flush = 1'b1; en = 1'b1; din = 8'h99; din_vld = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0;
    chk("rst2_count", 32'(count), 32'd0);
    chk("rst2_full",  32'(full),  32'd0);
    tap(3'd2, 8'h00, 1'b0, "rst2_tap2");
    tap(3'd4, 8'h00, 1'b0, "rst2_tap4");
    din = 8'hC3; din_vld = 1'b1; en = 1'b1; sel = 3'd2;
    tick();
    din = 8'h00; din_vld = 1'b0;
    tap(3'd2, 8'h00, 1'b0, "post_rst_e1");
    chk("post_rst_count1", 32'(count), 32'd1);
    tick();
    tap(3'd2, 8'hC3, 1'b1, "post_rst_e2");
    chk("post_rst_count2", 32'(count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
